// File: rtl/page_sexa_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : page_sexa_arbiter_if
//  Description : Bundle of the six leaf packet inputs, the merged upstream
//                output and the status signals of page_sexa_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface page_sexa_arbiter_if #(
  parameter int PKT_W = 49
);
  logic [PKT_W-1:0] din_leaf_interface2bft_0;
  logic [PKT_W-1:0] din_leaf_interface2bft_1;
  logic [PKT_W-1:0] din_leaf_interface2bft_2;
  logic [PKT_W-1:0] din_leaf_interface2bft_3;
  logic [PKT_W-1:0] din_leaf_interface2bft_4;
  logic [PKT_W-1:0] din_leaf_interface2bft_5;
  logic [5:0]       port_en;
  logic             dout_ready;
  logic [PKT_W-1:0] dout_leaf_interface2bft;
  logic [2:0]       dout_port;
  logic             resend_0;
  logic             resend_1;
  logic             resend_2;
  logic             resend_3;
  logic             resend_4;
  logic             resend_5;
  logic [5:0]       full;
  logic [7:0]       drop_cnt;

  // Leaf side / upstream consumer: drives packets and flow control.
  modport master (
    output din_leaf_interface2bft_0, din_leaf_interface2bft_1,
           din_leaf_interface2bft_2, din_leaf_interface2bft_3,
           din_leaf_interface2bft_4, din_leaf_interface2bft_5,
           port_en, dout_ready,
    input  dout_leaf_interface2bft, dout_port,
           resend_0, resend_1, resend_2, resend_3, resend_4, resend_5,
           full, drop_cnt
  );

  // Arbiter side.
  modport slave (
    input  din_leaf_interface2bft_0, din_leaf_interface2bft_1,
           din_leaf_interface2bft_2, din_leaf_interface2bft_3,
           din_leaf_interface2bft_4, din_leaf_interface2bft_5,
           port_en, dout_ready,
    output dout_leaf_interface2bft, dout_port,
           resend_0, resend_1, resend_2, resend_3, resend_4, resend_5,
           full, drop_cnt
  );
endinterface
`default_nettype wire

// File: rtl/page_sexa_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : page_sexa_arbiter
//  Description : Six-port round-robin packet merger. Each leaf port feeds a
//                small FIFO; one packet per cycle is granted into a registered
//                upstream output with valid/ready backpressure. Packets that
//                hit a full FIFO are dropped and flagged for resend.
//  Revision    : 1.0  initial release
// ============================================================================
module page_sexa_arbiter #(
  parameter int PKT_W      = 49,
  parameter int N_PORTS    = 6,
  parameter int FIFO_DEPTH = 2
) (
  input logic                clk,
  input logic                reset_n,
  page_sexa_arbiter_if.slave bus
);

  localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
  localparam logic [c_cnt_w-1:0] c_full_cnt  = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_ptr_w-1:0] c_last_ptr  = c_ptr_w'(FIFO_DEPTH - 1);
  localparam logic [2:0]         c_last_port = 3'(N_PORTS - 1);

  logic [PKT_W-1:0]   w_din  [N_PORTS];
  logic [PKT_W-1:0]   w_head [N_PORTS];
  logic [N_PORTS-1:0] w_push;
  logic [N_PORTS-1:0] w_pop;
  logic [N_PORTS-1:0] w_drop;
  logic [N_PORTS-1:0] w_empty;
  logic [N_PORTS-1:0] w_full;
  logic [N_PORTS-1:0] w_elig;
  logic               w_load;
  logic               w_found;
  logic [2:0]         w_grant;
  logic [PKT_W-1:0]   w_sel;
  logic [3:0]         w_drop_num;
  logic [8:0]         w_drop_sum;

  logic [PKT_W-1:0]   r_dout;
  logic [2:0]         r_dout_port;
  logic [2:0]         r_rr_ptr;
  logic [N_PORTS-1:0] r_resend;
  logic [7:0]         r_drop_cnt;

  assign w_din[0] = bus.din_leaf_interface2bft_0;
  assign w_din[1] = bus.din_leaf_interface2bft_1;
  assign w_din[2] = bus.din_leaf_interface2bft_2;
  assign w_din[3] = bus.din_leaf_interface2bft_3;
  assign w_din[4] = bus.din_leaf_interface2bft_4;
  assign w_din[5] = bus.din_leaf_interface2bft_5;

  // The output register may take a new packet when it is empty or drained.
  assign w_load = ~r_dout[PKT_W-1] | bus.dout_ready;
  assign w_elig = ~w_empty & bus.port_en;

  // ---------------------------------------------------------------------------
  // Per-port FIFO. A full FIFO still accepts a packet when its head is popped
  // in the same cycle, so a continuously drained port never drops.
  // ---------------------------------------------------------------------------
  generate
    for (genvar g = 0; g < N_PORTS; g++) begin : g_port
      logic [PKT_W-1:0]   r_mem [FIFO_DEPTH];
      logic [c_ptr_w-1:0] r_wr_ptr;
      logic [c_ptr_w-1:0] r_rd_ptr;
      logic [c_cnt_w-1:0] r_count;
      logic [c_cnt_w-1:0] w_count_next;
      logic               r_full;
      logic               w_valid;

      assign w_valid    = w_din[g][PKT_W-1];
      assign w_push[g]  = w_valid & (~r_full | w_pop[g]);
      assign w_drop[g]  = w_valid & r_full & ~w_pop[g];
      assign w_empty[g] = (r_count == '0);
      assign w_full[g]  = r_full;
      assign w_head[g]  = r_mem[r_rd_ptr];

      // Occupancy after this edge, used for the registered full flag.
      always_comb begin
        w_count_next = r_count;
        if (w_push[g] && !w_pop[g]) begin
          w_count_next = r_count + c_cnt_w'(1);
        end else if (!w_push[g] && w_pop[g]) begin
          w_count_next = r_count - c_cnt_w'(1);
        end
      end

      // Pointer, count and full-flag state.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_wr_ptr <= '0;
          r_rd_ptr <= '0;
          r_count  <= '0;
          r_full   <= 1'b0;
        end else begin
          if (w_push[g]) begin
            r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + c_ptr_w'(1);
          end
          if (w_pop[g]) begin
            r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + c_ptr_w'(1);
          end
          r_count <= w_count_next;
          r_full  <= (w_count_next == c_full_cnt);
        end
      end

      // Packet storage; contents are don't-care while the count says empty.
      always_ff @(posedge clk) begin
        if (w_push[g]) begin
          r_mem[r_wr_ptr] <= w_din[g];
        end
      end
    end
  endgenerate

  // Round-robin search: lowest eligible port at or above rr_ptr, else wrap.
  always_comb begin
    w_found = 1'b0;
    w_grant = r_rr_ptr;
    for (int p = N_PORTS - 1; p >= 0; p--) begin
      if (w_elig[p] && (3'(p) >= r_rr_ptr)) begin
        w_found = 1'b1;
        w_grant = 3'(p);
      end
    end
    if (!w_found) begin
      for (int p = N_PORTS - 1; p >= 0; p--) begin
        if (w_elig[p]) begin
          w_found = 1'b1;
          w_grant = 3'(p);
        end
      end
    end
  end

  // Pop the granted FIFO and pick its head for the output register.
  always_comb begin
    w_sel = '0;
    w_pop = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (w_load && w_found && (w_grant == 3'(p))) begin
        w_pop[p] = 1'b1;
        w_sel    = w_head[p];
      end
    end
  end

  // Number of drops this cycle and the unsaturated running total.
  always_comb begin
    w_drop_num = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      w_drop_num = w_drop_num + {3'b000, w_drop[p]};
    end
    w_drop_sum = {1'b0, r_drop_cnt} + {5'b00000, w_drop_num};
  end

  // Output register, round-robin pointer, resend pulses and drop counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dout      <= '0;
      r_dout_port <= '0;
      r_rr_ptr    <= '0;
      r_resend    <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_resend   <= w_drop;
      r_drop_cnt <= (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];
      if (w_load) begin
        if (w_found) begin
          r_dout      <= w_sel;
          r_dout_port <= w_grant;
          r_rr_ptr    <= (w_grant == c_last_port) ? 3'd0 : w_grant + 3'd1;
        end else begin
          r_dout <= '0;
        end
      end
    end
  end

  assign bus.dout_leaf_interface2bft = r_dout;
  assign bus.dout_port               = r_dout_port;
  assign bus.resend_0                = r_resend[0];
  assign bus.resend_1                = r_resend[1];
  assign bus.resend_2                = r_resend[2];
  assign bus.resend_3                = r_resend[3];
  assign bus.resend_4                = r_resend[4];
  assign bus.resend_5                = r_resend[5];
  assign bus.full                    = w_full;
  assign bus.drop_cnt                = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_page_sexa_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_page_sexa_arbiter
//  Description : Directed table-driven bench for page_sexa_arbiter plus
//                hand-written saturation and asynchronous reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_page_sexa_arbiter;
  localparam int PKT_W = 49;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  page_sexa_arbiter_if #(.PKT_W(PKT_W)) bus ();

  page_sexa_arbiter #(
    .PKT_W      (PKT_W),
    .N_PORTS    (6),
    .FIFO_DEPTH (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [5:0] resend_v;
  assign resend_v = {bus.resend_5, bus.resend_4, bus.resend_3,
                     bus.resend_2, bus.resend_1, bus.resend_0};

  typedef struct {
    logic [5:0] vld;
    logic [7:0] tag;
    logic [5:0] en;
    logic       rdy;
    logic       ev;
    logic [2:0] ep;
    logic [7:0] et;
    logic [5:0] efull;
    logic [5:0] eres;
    logic [7:0] edrop;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic [5:0] vld, logic [7:0] tag, logic [5:0] en,
                              logic rdy, logic ev, logic [2:0] ep, logic [7:0] et,
                              logic [5:0] efull, logic [5:0] eres, logic [7:0] edrop);
    vec_t v;
    v.vld = vld; v.tag = tag; v.en = en; v.rdy = rdy; v.ev = ev;
    v.ep = ep; v.et = et; v.efull = efull; v.eres = eres; v.edrop = edrop;
    return v;
  endfunction

  // Packet identifying its source port and a sequence tag.
  function automatic logic [PKT_W-1:0] pkt(int p, logic [7:0] tag);
    return {1'b1, 36'h0, tag, 4'(p)};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(logic [5:0] vld, logic [7:0] tag);
    bus.din_leaf_interface2bft_0 = vld[0] ? pkt(0, tag) : '0;
    bus.din_leaf_interface2bft_1 = vld[1] ? pkt(1, tag) : '0;
    bus.din_leaf_interface2bft_2 = vld[2] ? pkt(2, tag) : '0;
    bus.din_leaf_interface2bft_3 = vld[3] ? pkt(3, tag) : '0;
    bus.din_leaf_interface2bft_4 = vld[4] ? pkt(4, tag) : '0;
    bus.din_leaf_interface2bft_5 = vld[5] ? pkt(5, tag) : '0;
  endtask

  task automatic chk_dout(string name, logic ev, logic [2:0] ep, logic [7:0] et);
    if (ev) chk({name, " dout"}, 64'(bus.dout_leaf_interface2bft), 64'(pkt(ep, et)));
    else    chk({name, " dout_valid"}, 64'(bus.dout_leaf_interface2bft[PKT_W-1]), 64'd0);
    chk({name, " dout_port"}, 64'(bus.dout_port), 64'(ep));
  endtask

  initial begin
    drive(6'h00, 8'h00);
    bus.port_en    = 6'h3F;
    bus.dout_ready = 1'b1;

    // Round-robin fairness: one packet per port, then a second batch queued.
    vt.push_back(mk(6'h3F, 8'h10, 6'h3F, 1, 0, 0, 8'h00, 6'h00, 6'h00, 0));
    vt.push_back(mk(6'h3F, 8'h11, 6'h3F, 1, 1, 0, 8'h10, 6'h3E, 6'h00, 0));
    vt.push_back(mk(6'h00, 8'h00, 6'h3F, 1, 1, 1, 8'h10, 6'h3C, 6'h00, 0));
    vt.push_back(mk(6'h00, 8'h00, 6'h3F, 1, 1, 2, 8'h10, 6'h38, 6'h00, 0));
    vt.push_back(mk(6'h00, 8'h00, 6'h3F, 1, 1, 3, 8'h10, 6'h30, 6'h00, 0));
    vt.push_back(mk(6'h00, 8'h00, 6'h3F, 1, 1, 4, 8'h10, 6'h20, 6'h00, 0));
    vt.push_back(mk(6'h00, 8'h00, 6'h3F, 1, 1, 5, 8'h10, 6'h00, 6'h00, 0));
    vt.push_back(mk(6'h00, 8'h00, 6'h3F, 1, 1, 0, 8'h11, 6'h00, 6'h00, 0));
    vt.push_back(mk(6'h00, 8'h00, 6'h3F, 1, 1, 1, 8'h11, 6'h00, 6'h00, 0));
    vt.push_back(mk(6'h00, 8'h00, 6'h3F, 1, 1, 2, 8'h11, 6'h00, 6'h00, 0));
    vt.push_back(mk(6'h00, 8'h00, 6'h3F, 1, 1, 3, 8'h11, 6'h00, 6'h00, 0));
    vt.push_back(mk(6'h00, 8'h00, 6'h3F, 1, 1, 4, 8'h11, 6'h00, 6'h00, 0));
    vt.push_back(mk(6'h00, 8'h00, 6'h3F, 1, 1, 5, 8'h11, 6'h00, 6'h00, 0));
    vt.push_back(mk(6'h00, 8'h00, 6'h3F, 1, 0, 5, 8'h00, 6'h00, 6'h00, 0));
    // Single packet latency, then rr_ptr=4 favours port 5 over port 0.
    vt.push_back(mk(6'h08, 8'h20, 6'h3F, 1, 0, 5, 8'h00, 6'h00, 6'h00, 0));
    vt.push_back(mk(6'h00, 8'h00, 6'h3F, 1, 1, 3, 8'h20, 6'h00, 6'h00, 0));
    vt.push_back(mk(6'h00, 8'h00, 6'h3F, 1, 0, 3, 8'h00, 6'h00, 6'h00, 0));
    vt.push_back(mk(6'h21, 8'h21, 6'h3F, 1, 0, 3, 8'h00, 6'h00, 6'h00, 0));
    vt.push_back(mk(6'h00, 8'h00, 6'h3F, 1, 1, 5, 8'h21, 6'h00, 6'h00, 0));
    vt.push_back(mk(6'h00, 8'h00, 6'h3F, 1, 1, 0, 8'h21, 6'h00, 6'h00, 0));
    vt.push_back(mk(6'h00, 8'h00, 6'h3F, 1, 0, 0, 8'h00, 6'h00, 6'h00, 0));
    // Masking: port 0 disabled keeps its packets buffered.
    vt.push_back(mk(6'h03, 8'h30, 6'h3E, 1, 0, 0, 8'h00, 6'h00, 6'h00, 0));
    vt.push_back(mk(6'h03, 8'h31, 6'h3E, 1, 1, 1, 8'h30, 6'h01, 6'h00, 0));
    vt.push_back(mk(6'h00, 8'h00, 6'h3E, 1, 1, 1, 8'h31, 6'h01, 6'h00, 0));
    vt.push_back(mk(6'h00, 8'h00, 6'h3E, 1, 0, 1, 8'h00, 6'h01, 6'h00, 0));
    vt.push_back(mk(6'h00, 8'h00, 6'h3F, 1, 1, 0, 8'h30, 6'h00, 6'h00, 0));
    vt.push_back(mk(6'h00, 8'h00, 6'h3F, 1, 1, 0, 8'h31, 6'h00, 6'h00, 0));
    vt.push_back(mk(6'h00, 8'h00, 6'h3F, 1, 0, 0, 8'h00, 6'h00, 6'h00, 0));
    // Backpressure overflow on port 2: fourth packet dropped.
    vt.push_back(mk(6'h04, 8'h40, 6'h3F, 0, 0, 0, 8'h00, 6'h00, 6'h00, 0));
    vt.push_back(mk(6'h04, 8'h41, 6'h3F, 0, 1, 2, 8'h40, 6'h00, 6'h00, 0));
    vt.push_back(mk(6'h04, 8'h42, 6'h3F, 0, 1, 2, 8'h40, 6'h04, 6'h00, 0));
    vt.push_back(mk(6'h04, 8'h43, 6'h3F, 0, 1, 2, 8'h40, 6'h04, 6'h04, 1));
    vt.push_back(mk(6'h00, 8'h00, 6'h3F, 0, 1, 2, 8'h40, 6'h04, 6'h00, 1));
    // Full FIFO with same-cycle pop accepts the new packet.
    vt.push_back(mk(6'h04, 8'h44, 6'h3F, 1, 1, 2, 8'h41, 6'h04, 6'h00, 1));
    vt.push_back(mk(6'h00, 8'h00, 6'h3F, 1, 1, 2, 8'h42, 6'h00, 6'h00, 1));
    vt.push_back(mk(6'h00, 8'h00, 6'h3F, 1, 1, 2, 8'h44, 6'h00, 6'h00, 1));
    vt.push_back(mk(6'h00, 8'h00, 6'h3F, 1, 0, 2, 8'h00, 6'h00, 6'h00, 1));
    // Simultaneous drops on several ports.
    vt.push_back(mk(6'h3F, 8'h50, 6'h3F, 0, 0, 2, 8'h00, 6'h00, 6'h00, 1));
    vt.push_back(mk(6'h3F, 8'h51, 6'h3F, 0, 1, 3, 8'h50, 6'h37, 6'h00, 1));
    vt.push_back(mk(6'h3F, 8'h52, 6'h3F, 0, 1, 3, 8'h50, 6'h3F, 6'h37, 6));
    vt.push_back(mk(6'h3F, 8'h53, 6'h3F, 0, 1, 3, 8'h50, 6'h3F, 6'h3F, 12));
    vt.push_back(mk(6'h00, 8'h00, 6'h3F, 0, 1, 3, 8'h50, 6'h3F, 6'h00, 12));

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk_dout("reset", 1'b0, 3'd0, 8'h00);
    chk("reset full", 64'(bus.full), 64'd0);
    chk("reset resend", 64'(resend_v), 64'd0);
    chk("reset drop_cnt", 64'(bus.drop_cnt), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      drive(vt[i].vld, vt[i].tag);
      bus.port_en    = vt[i].en;
      bus.dout_ready = vt[i].rdy;
      @(posedge clk);
      #1;
      chk_dout($sformatf("row%0d", i), vt[i].ev, vt[i].ep, vt[i].et);
      chk($sformatf("row%0d full", i), 64'(bus.full), 64'(vt[i].efull));
      chk($sformatf("row%0d resend", i), 64'(resend_v), 64'(vt[i].eres));
      chk($sformatf("row%0d drop_cnt", i), 64'(bus.drop_cnt), 64'(vt[i].edrop));
    end

    // Drop counter saturation: six drops per cycle from a count of 12.
    for (int k = 1; k <= 42; k++) begin
      @(negedge clk);
      drive(6'h3F, 8'h70);
      bus.dout_ready = 1'b0;
      @(posedge clk);
      #1;
      if (k == 40) chk("sat drop_cnt 252", 64'(bus.drop_cnt), 64'd252);
      if (k >= 41) chk($sformatf("sat drop_cnt k%0d", k), 64'(bus.drop_cnt), 64'd255);
    end
    chk("sat resend", 64'(resend_v), 64'h3F);

    // Asynchronous reset between edges during traffic.
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk_dout("async", 1'b0, 3'd0, 8'h00);
    chk("async full", 64'(bus.full), 64'd0);
    chk("async resend", 64'(resend_v), 64'd0);
    chk("async drop_cnt", 64'(bus.drop_cnt), 64'd0);
    @(posedge clk);
    #1;
    chk("async hold full", 64'(bus.full), 64'd0);
    chk("async hold resend", 64'(resend_v), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(6'h00, 8'h00);
    bus.din_leaf_interface2bft_3 = 49'h1_0000_0000_00AB;
    bus.dout_ready = 1'b1;
    bus.port_en    = 6'h3F;
    @(posedge clk);
    #1;
    chk("post dout_valid", 64'(bus.dout_leaf_interface2bft[PKT_W-1]), 64'd0);
    chk("post resend", 64'(resend_v), 64'd0);
    @(negedge clk);
    drive(6'h11, 8'h60);
    @(posedge clk);
    #1;
    chk("post dout", 64'(bus.dout_leaf_interface2bft), 64'h1_0000_0000_00AB);
    chk("post dout_port", 64'(bus.dout_port), 64'd3);
    chk("post drop_cnt", 64'(bus.drop_cnt), 64'd0);
    @(negedge clk);
    drive(6'h00, 8'h00);
    @(posedge clk);
    #1;
    chk_dout("post rr4", 1'b1, 3'd4, 8'h60);
    @(posedge clk);
    #1;
    chk_dout("post rr0", 1'b1, 3'd0, 8'h60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
